// File: rtl/scan_mux.sv
// Registered N-channel, W-bit multiplexer for the shared sampling/display path.
// Channels are picked directly by sel (MANUAL) or stepped through a mask with a programmable dwell (SCAN).
module scan_mux #(
    parameter int N_CH    = 8,
    parameter int W       = 8,
    parameter int SEL_W   = $clog2(N_CH),
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   in,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [N_CH-1:0]     en_mask,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [W-1:0]        y,
    output logic [SEL_W-1:0]    y_ch,
    output logic                y_valid,
    output logic                wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic               starved;
    logic               starved_nxt;
    logic               wrap_nxt;
    logic               valid_nxt;

    logic [SEL_W-1:0]   first_idx;
    logic [SEL_W-1:0]   next_idx;
    logic               found_next;
    logic               mask_any;
    logic [SEL_W-1:0]   sel_ch;

    assign mask_any = |en_mask;
    assign sel_ch   = (int'(sel) >= N_CH) ? SEL_W'(N_CH - 1) : sel;

    // Priority search from the top down so the last hit is the lowest match.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        found_next = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                first_idx = SEL_W'(i);
                if (i > int'(ptr)) begin
                    next_idx   = SEL_W'(i);
                    found_next = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (!en) begin
            state_nxt = IDLE;
        end else if (mode) begin
            state_nxt = SCAN;
        end else begin
            state_nxt = MANUAL;
        end
    end

    // starved marks a scan parked on an empty mask; the first non-empty mask restarts from the lowest channel.
    always_comb begin
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        starved_nxt = starved;
        wrap_nxt    = 1'b0;
        valid_nxt   = (state == MANUAL) || ((state == SCAN) && mask_any && !starved);
        case (state_nxt)
            MANUAL: begin
                ptr_nxt     = sel_ch;
                cnt_nxt     = '0;
                starved_nxt = 1'b0;
            end
            SCAN: begin
                if ((state != SCAN) || starved) begin
                    cnt_nxt = '0;
                    if (mask_any) begin
                        ptr_nxt     = first_idx;
                        starved_nxt = 1'b0;
                    end else begin
                        starved_nxt = 1'b1;
                    end
                end else if (!mask_any) begin
                    starved_nxt = 1'b1;
                end else if (!en_mask[ptr] || (cnt >= dwell)) begin
                    cnt_nxt = '0;
                    if (found_next) begin
                        ptr_nxt = next_idx;
                    end else begin
                        ptr_nxt  = first_idx;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + DWELL_W'(1);
                end
            end
            default: begin
                starved_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            starved <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            starved <= starved_nxt;
        end
    end

    // Output stage: y/y_ch freeze while idle so the display keeps the last sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            if (state != IDLE) begin
                y    <= in[int'(ptr)*W +: W];
                y_ch <= ptr;
            end
            y_valid <= valid_nxt;
            wrap    <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: table-driven MANUAL vectors plus hand-built SCAN sequences,
// with expectations queued at drive time and compared when their output cycle arrives.
module tb_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  en_mask;
    logic [7:0]  dwell;
    logic [7:0]  y;
    logic [2:0]  y_ch;
    logic        y_valid;
    logic        wrap;

    logic [47:0] in6;
    logic [2:0]  sel6;
    logic [5:0]  mask6;
    logic [7:0]  y6;
    logic [2:0]  ych6;
    logic        v6;
    logic        w6;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] ey;
        logic [2:0] ech;
        logic [2:0] sel6;
        logic [7:0] ey6;
        logic [2:0] ech6;
    } vec_t;

    typedef struct {
        int         due;
        string      nm;
        bit         cy;
        logic [7:0] y;
        logic [2:0] ch;
        logic       v;
        logic       w;
        bit         c6;
        logic [7:0] y6;
        logic [2:0] ch6;
    } exp_t;

    exp_t sb[$];
    exp_t ent;
    int   scanSeq [15] = '{1, 1, 1, 2, 2, 2, 5, 5, 5, 7, 7, 7, 1, 1, 1};

    scan_mux dut (
        .clk(clk), .rst(rst), .in(in), .en(en), .mode(mode), .sel(sel),
        .en_mask(en_mask), .dwell(dwell),
        .y(y), .y_ch(y_ch), .y_valid(y_valid), .wrap(wrap)
    );

    scan_mux #(.N_CH(6)) dut6 (
        .clk(clk), .rst(rst), .in(in6), .en(en), .mode(mode), .sel(sel6),
        .en_mask(mask6), .dwell(dwell),
        .y(y6), .y_ch(ych6), .y_valid(v6), .wrap(w6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic m, input logic [2:0] s,
                                 input logic [7:0] msk, input logic [7:0] dw);
        en      = e;
        mode    = m;
        sel     = s;
        en_mask = msk;
        dwell   = dw;
    endtask

    task automatic pushExpect(input int due, input string nm, input bit cy, input logic [7:0] ey,
                              input logic [2:0] ech, input logic ev, input logic ew);
        sb.push_back('{due: due, nm: nm, cy: cy, y: ey, ch: ech, v: ev, w: ew,
                       c6: 1'b0, y6: 8'h00, ch6: 3'd0});
    endtask

    task automatic waitCyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s: expectation never compared (due %0d, now %0d)", e.nm, e.due, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                ent = sb.pop_front();
                if (ent.due < cyc) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s: missed compare slot %0d, now %0d", ent.nm, ent.due, cyc);
                end else begin
                    if (ent.cy) begin
                        checkOutput({ent.nm, "/data"}, 32'({y_ch, y}), 32'({ent.ch, ent.y}));
                    end
                    checkOutput({ent.nm, "/flags"}, 32'({y_valid, wrap}), 32'({ent.v, ent.w}));
                    if (ent.c6) begin
                        checkOutput({ent.nm, "/n6"}, 32'({ych6, y6}), 32'({ent.ch6, ent.y6}));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl [6];
        int   c;

        tbl[0] = '{3'd5, 8'h15, 3'd5, 3'd7, 8'h25, 3'd5};
        tbl[1] = '{3'd0, 8'h10, 3'd0, 3'd5, 8'h25, 3'd5};
        tbl[2] = '{3'd3, 8'h13, 3'd3, 3'd6, 8'h25, 3'd5};
        tbl[3] = '{3'd7, 8'h17, 3'd7, 3'd2, 8'h22, 3'd2};
        tbl[4] = '{3'd1, 8'h11, 3'd1, 3'd0, 8'h20, 3'd0};
        tbl[5] = '{3'd6, 8'h16, 3'd6, 3'd4, 8'h24, 3'd4};

        for (int k = 0; k < 8; k++) in[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 6; k++) in6[k*8 +: 8] = 8'h20 + 8'(k);
        sel6  = 3'd0;
        mask6 = 6'h3F;
        rst   = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

        #3 rst = 1'b1;
        #1 checkOutput("reset_init/data", 32'({y_ch, y}), 32'(0));
        checkOutput("reset_init/flags", 32'({y_valid, wrap}), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset/data", 32'({y_ch, y}), 32'(0));
        checkOutput("idle_after_reset/flags", 32'({y_valid, wrap}), 32'(0));

        // MANUAL: select lands in y two edges after it is driven; the 6-channel copy clamps sel>=6
        for (int i = 0; i < 6; i++) begin
            c = cyc;
            applyStimulus(1'b1, 1'b0, tbl[i].sel, 8'h00, 8'h00);
            sel6 = tbl[i].sel6;
            sb.push_back('{due: c + 2, nm: $sformatf("manual[%0d]", i), cy: 1'b1,
                           y: tbl[i].ey, ch: tbl[i].ech, v: 1'b1, w: 1'b0,
                           c6: 1'b1, y6: tbl[i].ey6, ch6: tbl[i].ech6});
            @(negedge clk);
        end

        // SCAN order over mask 1010_0110 with dwell 2, wrap as ptr returns 7 -> 1
        c = cyc;
        applyStimulus(1'b1, 1'b1, 3'd6, 8'hA6, 8'd2);
        for (int k = 0; k < 15; k++) begin
            pushExpect(c + 2 + k, $sformatf("scan[%0d]", k), 1'b1, 8'h10 + 8'(scanSeq[k]),
                       3'(scanSeq[k]), 1'b1, (k == 11));
        end
        waitCyc(c + 16);

        // dwell 0 on a single-channel mask: constant channel, wrap every cycle
        c = cyc;
        en = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 3'd0, 8'h08, 8'd0);
        pushExpect(c + 2, "idle_gap", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            pushExpect(c + 3 + k, $sformatf("single[%0d]", k), 1'b1, 8'h13, 3'd3, 1'b1, 1'b1);
        end
        waitCyc(c + 7);

        // empty mask: no valid, no wrap
        c = cyc;
        en_mask = 8'h00;
        for (int k = 1; k <= 3; k++) begin
            pushExpect(c + k, $sformatf("empty[%0d]", k), 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        end
        waitCyc(c + 3);

        // recovery to lowest channel, mid-dwell mask drop, dwell lowered below cnt, live data
        c = cyc;
        en_mask = 8'h34;
        dwell   = 8'd5;
        pushExpect(c + 2,  "drop_a", 1'b1, 8'h12, 3'd2, 1'b1, 1'b0);
        pushExpect(c + 3,  "drop_b", 1'b1, 8'h12, 3'd2, 1'b1, 1'b0);
        for (int k = 4; k <= 7; k++) begin
            pushExpect(c + k, $sformatf("hold4[%0d]", k), 1'b1, 8'h14, 3'd4, 1'b1, 1'b0);
        end
        pushExpect(c + 8,  "fast_a", 1'b1, 8'h15, 3'd5, 1'b1, 1'b1);
        pushExpect(c + 9,  "live",   1'b1, 8'hA4, 3'd4, 1'b1, 1'b0);
        pushExpect(c + 10, "fast_b", 1'b1, 8'h15, 3'd5, 1'b1, 1'b1);
        waitCyc(c + 2);
        en_mask = 8'h30;
        waitCyc(c + 6);
        dwell = 8'd0;
        waitCyc(c + 8);
        in[4*8 +: 8] = 8'hA4;
        waitCyc(c + 10);

        // mode switching: SCAN on 5 -> MANUAL sel 2 -> SCAN restart -> disable holds y
        c = cyc;
        in[4*8 +: 8] = 8'h14;
        en_mask = 8'h20;
        dwell   = 8'd200;
        pushExpect(c + 1, "to5_a", 1'b1, 8'h14, 3'd4, 1'b1, 1'b0);
        pushExpect(c + 2, "to5_b", 1'b1, 8'h15, 3'd5, 1'b1, 1'b0);
        waitCyc(c + 2);
        mode = 1'b0;
        sel  = 3'd2;
        pushExpect(c + 3, "sw_man_a", 1'b1, 8'h15, 3'd5, 1'b1, 1'b0);
        pushExpect(c + 4, "sw_man_b", 1'b1, 8'h12, 3'd2, 1'b1, 1'b0);
        waitCyc(c + 4);
        mode    = 1'b1;
        en_mask = 8'hA6;
        dwell   = 8'd3;
        pushExpect(c + 5, "sw_scan_a", 1'b1, 8'h12, 3'd2, 1'b1, 1'b0);
        for (int k = 6; k <= 9; k++) begin
            pushExpect(c + k, $sformatf("restart[%0d]", k), 1'b1, 8'h11, 3'd1, 1'b1, 1'b0);
        end
        pushExpect(c + 10, "restart_adv", 1'b1, 8'h12, 3'd2, 1'b1, 1'b0);
        waitCyc(c + 10);
        en = 1'b0;
        pushExpect(c + 11, "dis_last", 1'b1, 8'h12, 3'd2, 1'b1, 1'b0);
        for (int k = 12; k <= 14; k++) begin
            pushExpect(c + k, $sformatf("dis_hold[%0d]", k), 1'b1, 8'h12, 3'd2, 1'b0, 1'b0);
        end
        waitCyc(c + 11);
        in[2*8 +: 8] = 8'h5A;
        drain();

        // asynchronous reset in the middle of a MANUAL run
        applyStimulus(1'b1, 1'b0, 3'd6, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset/data", 32'({y_ch, y}), 32'({3'd6, 8'h16}));
        checkOutput("pre_reset/flags", 32'({y_valid, wrap}), 32'({1'b1, 1'b0}));
        #2 rst = 1'b1;
        #1 checkOutput("async_reset/data", 32'({y_ch, y}), 32'(0));
        checkOutput("async_reset/flags", 32'({y_valid, wrap}), 32'(0));
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_reset/data", 32'({y_ch, y}), 32'(0));
        checkOutput("post_reset/flags", 32'({y_valid, wrap}), 32'(0));

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
